// File: rtl/rotate_issue_pipe_if.sv
// Operand, shifter and result signals shared by rotate_issue_pipe and its neighbours.
// The slave view belongs to the pipe; the master view belongs to the source/shifter/consumer side.
interface rotate_issue_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int SHIFT_W = 5,
    parameter int COUNT_W = 16
);
    logic               inValid;
    logic               inReady;
    logic [WIDTH-1:0]   inputData;
    logic [SHIFT_W-1:0] shiftVal;
    logic               selLeftOrRightRotate;
    logic [WIDTH-1:0]   shData;
    logic [SHIFT_W-1:0] shAmt;
    logic [WIDTH-1:0]   shResult;
    logic               outValid;
    logic               outReady;
    logic [WIDTH-1:0]   outputData;
    logic [COUNT_W-1:0] opCount;

    modport slave (
        input  inValid, inputData, shiftVal, selLeftOrRightRotate, shResult, outReady,
        output inReady, shData, shAmt, outValid, outputData, opCount
    );

    modport master (
        output inValid, inputData, shiftVal, selLeftOrRightRotate, shResult, outReady,
        input  inReady, shData, shAmt, outValid, outputData, opCount
    );
endinterface

// File: rtl/rotate_issue_pipe.sv
// Two-stage valid/ready pipe feeding an external combinational left-rotator.
// Right rotates are turned into left rotates on entry so the shifter needs no direction input.
module rotate_issue_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHIFT_W = 5,
    parameter int COUNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    rotate_issue_pipe_if.slave  bus
);

    // Right by n equals left by WIDTH-n; the modular subtraction keeps n=0 at 0.
    function automatic logic [SHIFT_W-1:0] norm_amt(input logic [SHIFT_W-1:0] amt,
                                                    input logic               left);
        logic [SHIFT_W-1:0] res;
        if (left) begin
            res = amt;
        end else begin
            res = {SHIFT_W{1'b0}} - amt;
        end
        return res;
    endfunction

    logic               s1_valid_r;
    logic [WIDTH-1:0]   sh_data_r;
    logic [SHIFT_W-1:0] sh_amt_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_data_r;
    logic [COUNT_W-1:0] op_count_r;

    logic s2_free_s;
    logic s1_move_s;
    logic in_ready_s;
    logic in_fire_s;
    logic out_fire_s;

    // Stage advance conditions; inReady follows outReady combinationally for full throughput.
    always_comb begin
        s2_free_s  = !out_valid_r || bus.outReady;
        s1_move_s  = s1_valid_r && s2_free_s;
        in_ready_s = !s1_valid_r || s1_move_s;
        in_fire_s  = bus.inValid && in_ready_s;
        out_fire_s = out_valid_r && bus.outReady;
    end

    // Stage 1: operand and normalised amount; payload holds its value after draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            sh_data_r  <= {WIDTH{1'b0}};
            sh_amt_r   <= {SHIFT_W{1'b0}};
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            sh_data_r  <= bus.inputData;
            sh_amt_r   <= norm_amt(bus.shiftVal, bus.selLeftOrRightRotate);
        end else if (s1_move_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: capture the shifter result and hold it until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
        end else if (s1_move_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= bus.shResult;
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Completed-operation counter, wraps naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_r <= {COUNT_W{1'b0}};
        end else if (out_fire_s) begin
            op_count_r <= op_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            op_count_r <= op_count_r;
        end
    end

    assign bus.inReady    = in_ready_s;
    assign bus.shData     = sh_data_r;
    assign bus.shAmt      = sh_amt_r;
    assign bus.outValid   = out_valid_r;
    assign bus.outputData = out_data_r;
    assign bus.opCount    = op_count_r;

endmodule

// File: tb/tb_rotate_issue_pipe.sv
// Directed and randomised checks of rotate_issue_pipe with a behavioural left-rotator attached.
module tb_rotate_issue_pipe;

    localparam int WIDTH   = 32;
    localparam int SHIFT_W = 5;
    localparam int COUNT_W = 16;
    localparam int N_RAND  = 10000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    rotate_issue_pipe_if #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .COUNT_W(COUNT_W)) bus ();

    rotate_issue_pipe #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .COUNT_W(COUNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    // Behavioural stand-in for the attached barrel shifter.
    assign bus.shResult = rotl(bus.shData, bus.shAmt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input logic [31:0] d, input logic [4:0] a, input logic left);
        bus.inValid              = 1'b1;
        bus.inputData            = d;
        bus.shiftVal             = a;
        bus.selLeftOrRightRotate = left;
    endtask

    // One isolated operation with outReady held high.
    task automatic single_op(input logic [31:0] d, input logic [4:0] a, input logic left,
                             input logic [4:0] exp_amt, input logic [31:0] exp_out);
        @(negedge clk);
        drive_op(d, a, left);
        #1 check_eq("single_inready", bus.inReady, 1);
        @(negedge clk);
        bus.inValid = 1'b0;
        check_eq("single_shamt", bus.shAmt, exp_amt);
        check_eq("single_early_valid", bus.outValid, 0);
        @(negedge clk);
        check_eq("single_valid", bus.outValid, 1);
        check_eq("single_data", bus.outputData, exp_out);
        @(negedge clk);
        check_eq("single_drained", bus.outValid, 0);
    endtask

    logic [31:0] stream_exp [8];
    logic [31:0] exp_q [$];
    logic [31:0] cur_exp;
    logic [31:0] rd;
    logic [4:0]  ra;
    logic        rl;
    logic        pend;
    int          sent;
    int          got;
    int          cyc;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.inValid              = 1'b0;
        bus.inputData            = 32'h0000_0000;
        bus.shiftVal             = 5'd0;
        bus.selLeftOrRightRotate = 1'b0;
        bus.outReady             = 1'b1;

        #1;
        check_eq("rst_outvalid", bus.outValid, 0);
        check_eq("rst_opcount", bus.opCount, 0);
        check_eq("rst_shdata", bus.shData, 0);
        check_eq("rst_shamt", bus.shAmt, 0);
        check_eq("rst_outdata", bus.outputData, 0);
        check_eq("rst_inready", bus.inReady, 1);
        @(negedge clk);
        rst = 1'b0;

        single_op(32'h8000_0001, 5'd4, 1'b1, 5'd4,  32'h0000_0018);
        single_op(32'h8000_0001, 5'd4, 1'b0, 5'd28, 32'h1800_0000);
        single_op(32'hDEAD_BEEF, 5'd0, 1'b0, 5'd0,  32'hDEAD_BEEF);
        single_op(32'hDEAD_BEEF, 5'd0, 1'b1, 5'd0,  32'hDEAD_BEEF);
        single_op(32'hDEAD_BEEF, 5'd1, 1'b0, 5'd31, 32'hEF56_DF77);
        check_eq("single_opcount", bus.opCount, 5);

        // Back-to-back stream: op i presented at negedge i appears at negedge i+2.
        for (int i = 0; i < 8; i++) begin
            stream_exp[i] = (i % 2 == 0) ? rotl(32'h0000_0001 << i, 5'(i))
                                         : rotr(32'hF000_0000 | 32'(i), 5'(i + 3));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) begin
                if (i % 2 == 0) drive_op(32'h0000_0001 << i, 5'(i), 1'b1);
                else            drive_op(32'hF000_0000 | 32'(i), 5'(i + 3), 1'b0);
            end else begin
                bus.inValid = 1'b0;
            end
            #1;
            if (i < 8) check_eq("stream_inready", bus.inReady, 1);
            if (i >= 2) begin
                check_eq("stream_valid", bus.outValid, 1);
                check_eq("stream_data", bus.outputData, stream_exp[i-2]);
            end
        end
        @(negedge clk);
        check_eq("stream_opcount", bus.opCount, 13);
        check_eq("stream_drained", bus.outValid, 0);

        // Back-pressure: two ops fill the pipe, the third waits.
        bus.outReady = 1'b0;
        drive_op(32'h0000_00A5, 5'd8, 1'b1);
        #1 check_eq("bp_inready_a", bus.inReady, 1);
        @(negedge clk);
        drive_op(32'h0000_00B6, 5'd4, 1'b1);
        #1 check_eq("bp_inready_b", bus.inReady, 1);
        @(negedge clk);
        drive_op(32'h0000_00C7, 5'd4, 1'b0);
        #1;
        check_eq("bp_full_inready", bus.inReady, 0);
        check_eq("bp_first_valid", bus.outValid, 1);
        check_eq("bp_first_data", bus.outputData, 32'h0000_A500);
        @(negedge clk);
        check_eq("bp_hold_inready", bus.inReady, 0);
        check_eq("bp_hold_data", bus.outputData, 32'h0000_A500);
        bus.outReady = 1'b1;
        #1 check_eq("bp_release_inready", bus.inReady, 1);
        @(negedge clk);
        bus.inValid = 1'b0;
        check_eq("bp_second_data", bus.outputData, 32'h0000_0B60);
        @(negedge clk);
        check_eq("bp_third_data", bus.outputData, 32'h7000_000C);
        @(negedge clk);
        check_eq("bp_drained", bus.outValid, 0);
        check_eq("bp_opcount", bus.opCount, 16);

        // Random valid/ready traffic against an independent rotate model.
        pend = 1'b0;
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((sent < N_RAND || exp_q.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!pend && sent < N_RAND && $urandom_range(0, 3) != 0) begin
                rd = $urandom;
                ra = 5'($urandom_range(0, 31));
                rl = 1'($urandom_range(0, 1));
                cur_exp = rl ? rotl(rd, ra) : rotr(rd, ra);
                drive_op(rd, ra, rl);
                pend = 1'b1;
            end
            bus.inValid  = pend;
            bus.outReady = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.outValid && bus.outReady) begin
                check_eq("rand_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check_eq("rand_data", bus.outputData, exp_q.pop_front());
                    got++;
                end
            end
            if (pend && bus.inReady) begin
                exp_q.push_back(cur_exp);
                sent++;
                pend = 1'b0;
            end
        end
        bus.inValid = 1'b0;
        check_eq("rand_complete", (sent == N_RAND) && (exp_q.size() == 0), 1);
        @(negedge clk);
        check_eq("rand_outvalid", bus.outValid, 0);
        check_eq("rand_opcount", bus.opCount, 16'(16 + N_RAND));

        // Asynchronous reset with both stages full: nothing in flight survives.
        bus.outReady = 1'b0;
        drive_op(32'h1234_5678, 5'd3, 1'b1);
        @(negedge clk);
        drive_op(32'h9ABC_DEF0, 5'd5, 1'b0);
        @(negedge clk);
        bus.inValid = 1'b0;
        #1 check_eq("arst_prefull", bus.outValid, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_outvalid", bus.outValid, 0);
        check_eq("arst_opcount", bus.opCount, 0);
        check_eq("arst_inready", bus.inReady, 1);
        @(negedge clk);
        rst = 1'b0;
        bus.outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("arst_no_output", bus.outValid, 0);
        end
        check_eq("arst_opcount_after", bus.opCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
